rvc_asap_dmem_arbiter: RTL

//  Two-requester arbiter and region decoder for the shared data-memory bus. Core data port (Core*) and external

---
 rtl/rvc_asap_dmem_arbiter_if.sv | 50 +++++
 rtl/rvc_asap_dmem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rvc_asap_dmem_arbiter_if.sv
// Shared data-memory bus bundle: Core and Ext request ports plus the memory command/read path.
// master = requesters and memory model, slave = the arbiter.
interface rvc_asap_dmem_arbiter_if;
   logic        CoreReq;
   logic [31:0] CoreAddr;
   logic        CoreWrEn;
   logic [3:0]  CoreByteEn;
   logic [31:0] CoreWrData;
   logic        CoreGnt;
   logic        CoreRspValid;
   logic        CoreRspErr;
   logic [31:0] CoreRdData;

   logic        ExtReq;
   logic [31:0] ExtAddr;
   logic        ExtWrEn;
   logic [3:0]  ExtByteEn;
   logic [31:0] ExtWrData;
   logic        ExtLock;
   logic        ExtGnt;
   logic        ExtRspValid;
   logic        ExtRspErr;
   logic [31:0] ExtRdData;

   logic        MemValid;
   logic [3:0]  MemRegionSel;
   logic [31:0] MemAddr;
   logic        MemWrEn;
   logic [3:0]  MemByteEn;
   logic [31:0] MemWrData;
   logic [31:0] MemRdData;

   modport master (
      output CoreReq, CoreAddr, CoreWrEn, CoreByteEn, CoreWrData,
      input  CoreGnt, CoreRspValid, CoreRspErr, CoreRdData,
      output ExtReq, ExtAddr, ExtWrEn, ExtByteEn, ExtWrData, ExtLock,
      input  ExtGnt, ExtRspValid, ExtRspErr, ExtRdData,
      input  MemValid, MemRegionSel, MemAddr, MemWrEn, MemByteEn, MemWrData,
      output MemRdData
   );

   modport slave (
      input  CoreReq, CoreAddr, CoreWrEn, CoreByteEn, CoreWrData,
      output CoreGnt, CoreRspValid, CoreRspErr, CoreRdData,
      input  ExtReq, ExtAddr, ExtWrEn, ExtByteEn, ExtWrData, ExtLock,
      output ExtGnt, ExtRspValid, ExtRspErr, ExtRdData,
      output MemValid, MemRegionSel, MemAddr, MemWrEn, MemByteEn, MemWrData,
      input  MemRdData
   );
endinterface

// File: rtl/rvc_asap_dmem_arbiter.sv
// Core/Ext arbiter with region decode for the shared data-memory bus. Core has priority,
// Ext is protected by a starvation counter and can lock the bus across several accesses.
module rvc_asap_dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                         Clock,
   input  logic                         Rst,
   rvc_asap_dmem_arbiter_if.slave       bus
);

   typedef enum logic {ARB_CORE, ARB_EXT} arb_state_e;

   localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

   arb_state_e  state_q, state_d;
   logic [7:0]  starve_cnt_q, starve_cnt_d;

   logic        core_gnt, ext_gnt, any_gnt;
   logic [31:0] sel_addr, sel_wr_data;
   logic        sel_wr_en;
   logic [3:0]  sel_byte_en;
   logic [3:0]  dec_region;
   logic        dec_err;

   logic        mem_valid_q, mem_valid_d;
   logic [3:0]  mem_region_q, mem_region_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_wr_en_q, mem_wr_en_d;
   logic [3:0]  mem_byte_en_q, mem_byte_en_d;
   logic [31:0] mem_wr_data_q, mem_wr_data_d;

   // Response tags travel with the command: stage 0 = issue cycle, stage 1 = response cycle.
   logic [1:0]  vld_pipe_q, vld_pipe_d;
   logic [1:0]  ext_pipe_q, ext_pipe_d;
   logic [1:0]  err_pipe_q, err_pipe_d;
   logic [1:0]  rd_pipe_q, rd_pipe_d;

   always_comb begin
      core_gnt     = 1'b0;
      ext_gnt      = 1'b0;
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      if (!Rst) begin
         case (state_q)
            ARB_CORE: begin
               if (bus.CoreReq)     core_gnt = 1'b1;
               else if (bus.ExtReq) ext_gnt  = 1'b1;
               if (ext_gnt) begin
                  starve_cnt_d = 8'd0;
                  if (bus.ExtLock) state_d = ARB_EXT;
               end else if (bus.ExtReq) begin
                  if (starve_cnt_q != 8'hFF) starve_cnt_d = starve_cnt_q + 8'd1;
                  if (starve_cnt_q >= LIMIT_M1) state_d = ARB_EXT;
               end
            end
            ARB_EXT: begin
               // Without a lock, Ext owns the bus for at most one access.
               ext_gnt = bus.ExtReq;
               if (ext_gnt)      starve_cnt_d = 8'd0;
               if (!bus.ExtLock) state_d = ARB_CORE;
            end
            default: state_d = ARB_CORE;
         endcase
      end
   end

   assign any_gnt     = core_gnt | ext_gnt;
   assign sel_addr    = ext_gnt ? bus.ExtAddr   : bus.CoreAddr;
   assign sel_wr_en   = ext_gnt ? bus.ExtWrEn   : bus.CoreWrEn;
   assign sel_byte_en = ext_gnt ? bus.ExtByteEn : bus.CoreByteEn;
   assign sel_wr_data = ext_gnt ? bus.ExtWrData : bus.CoreWrData;

   always_comb begin
      dec_region = 4'b0000;
      dec_err    = 1'b0;
      if (sel_addr < 32'h0000_4000)      dec_region = 4'b0001;
      else if (sel_addr < 32'h0000_7000) dec_region = 4'b0010;
      else if (sel_addr < 32'h0000_8000) dec_region = 4'b0100;
      else if (sel_addr < 32'h0001_1600) dec_region = 4'b1000;
      else                               dec_err    = 1'b1;
      // Instruction memory is writable only through the loader port.
      if (core_gnt && sel_wr_en && dec_region[0]) begin
         dec_err    = 1'b1;
         dec_region = 4'b0000;
      end
   end

   always_comb begin
      mem_valid_d   = any_gnt & ~dec_err;
      mem_region_d  = mem_valid_d ? dec_region  : 4'b0000;
      mem_addr_d    = mem_valid_d ? sel_addr    : 32'd0;
      mem_wr_en_d   = mem_valid_d & sel_wr_en;
      mem_byte_en_d = mem_valid_d ? sel_byte_en : 4'b0000;
      mem_wr_data_d = mem_valid_d ? sel_wr_data : 32'd0;
      vld_pipe_d    = {vld_pipe_q[0], any_gnt};
      ext_pipe_d    = {ext_pipe_q[0], ext_gnt};
      err_pipe_d    = {err_pipe_q[0], any_gnt & dec_err};
      rd_pipe_d     = {rd_pipe_q[0],  mem_valid_d & ~sel_wr_en};
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         state_q       <= ARB_CORE;
         starve_cnt_q  <= 8'd0;
         mem_valid_q   <= 1'b0;
         mem_region_q  <= 4'b0000;
         mem_addr_q    <= 32'd0;
         mem_wr_en_q   <= 1'b0;
         mem_byte_en_q <= 4'b0000;
         mem_wr_data_q <= 32'd0;
         vld_pipe_q    <= 2'b00;
         ext_pipe_q    <= 2'b00;
         err_pipe_q    <= 2'b00;
         rd_pipe_q     <= 2'b00;
      end else begin
         state_q       <= state_d;
         starve_cnt_q  <= starve_cnt_d;
         mem_valid_q   <= mem_valid_d;
         mem_region_q  <= mem_region_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_byte_en_q <= mem_byte_en_d;
         mem_wr_data_q <= mem_wr_data_d;
         vld_pipe_q    <= vld_pipe_d;
         ext_pipe_q    <= ext_pipe_d;
         err_pipe_q    <= err_pipe_d;
         rd_pipe_q     <= rd_pipe_d;
      end
   end

   assign bus.CoreGnt      = core_gnt;
   assign bus.ExtGnt       = ext_gnt;
   assign bus.MemValid     = mem_valid_q;
   assign bus.MemRegionSel = mem_region_q;
   assign bus.MemAddr      = mem_addr_q;
   assign bus.MemWrEn      = mem_wr_en_q;
   assign bus.MemByteEn    = mem_byte_en_q;
   assign bus.MemWrData    = mem_wr_data_q;

   assign bus.CoreRspValid = vld_pipe_q[1] & ~ext_pipe_q[1];
   assign bus.CoreRspErr   = vld_pipe_q[1] & ~ext_pipe_q[1] & err_pipe_q[1];
   assign bus.CoreRdData   = (vld_pipe_q[1] & ~ext_pipe_q[1] & rd_pipe_q[1]) ? bus.MemRdData : 32'd0;
   assign bus.ExtRspValid  = vld_pipe_q[1] & ext_pipe_q[1];
   assign bus.ExtRspErr    = vld_pipe_q[1] & ext_pipe_q[1] & err_pipe_q[1];
   assign bus.ExtRdData    = (vld_pipe_q[1] & ext_pipe_q[1] & rd_pipe_q[1]) ? bus.MemRdData : 32'd0;

endmodule
